ysyx_24090012_fetch_stage: RTL and testbench
============================================

// Module: ysyx_24090012_fetch_stage
// PURPOSE
//  Multi-cycle instruction fetch stage in front of the decode/execute datapath.
//  Owns the architectural PC and issues one request per instruction to instruction memory
//  over a valid/ready request and valid response bus. Holds the returned word until
//  decode accepts it, then waits for the next PC from execute/writeback before fetching again.
//  Non-speculative: at most one instruction in flight.
// PARAMETERS
//  RESET_PC  32'h8000_0000  PC loaded on reset
//  NOP_INST  32'h0000_0013  word presented on a fetch fault (addi x0,x0,0)
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst            in   1   synchronous, active-high reset
//  imem_req_valid out  1   fetch request valid
//  imem_req_ready in   1   memory accepts request
//  imem_req_addr  out  32  word-aligned fetch address
//  imem_rsp_valid in   1   response valid (one cycle per request)
//  imem_rsp_data  in   32  instruction word
//  imem_rsp_err   in   1   access fault on this response
//  inst_valid     out  1   instruction available to decode
//  inst_ready     in   1   decode accepts instruction
//  inst           out  32  instruction word
//  inst_pc        out  32  PC of inst
//  inst_fault     out  1   inst is a faulted fetch (inst==NOP_INST)
//  npc_valid      in   1   next PC from execute is valid (one pulse per instruction)
//  npc            in   32  next PC (seq, branch, jal/jalr, mtvec on ecall, mepc on mret)
//  pc             out  32  current architectural PC
// BEHAVIOUR
//  Clock and reset: single clk. rst is synchronous and active-high.
//  Reset values: pc=RESET_PC, state=S_REQ, inst=0, inst_pc=0, inst_fault=0; all valids are 0 while rst=1.
//  FSM:
//   S_REQ:  imem_req_valid=1, imem_req_addr={pc[31:2],2'b00}. On req_valid&&req_ready -> S_WAIT.
//           req_valid and addr stay stable until accepted.
//   S_WAIT: on imem_rsp_valid, register inst=rsp_data (NOP_INST if rsp_err), inst_pc=pc,
//           inst_fault=rsp_err -> S_OUT. rsp_valid in the same cycle as the request handshake is ignored.
//   S_OUT:  inst_valid=1 with inst/inst_pc/inst_fault held stable. On inst_ready -> S_NPC.
//   S_NPC:  on npc_valid, pc<=npc -> S_REQ.
//  Latency: best case of 4 cycles per instruction. Timeline: req accepted at cycle T,
//   rsp at T+1, inst_valid at T+2, accepted at T+2, npc at T+3, next req_valid at T+4.
//  Boundary conditions:
//   - imem_rsp_valid outside S_WAIT and npc_valid outside S_NPC are ignored.
//   - Same-cycle npc_valid in S_OUT is not captured.
//   - pc changes only in S_NPC (and on reset); npc=pc (self-loop) is legal.
//   - Reset mid-operation abandons any outstanding request; memory is reset by the same rst.
//   - 32-bit PC wraps naturally (0xFFFF_FFFC -> npc 0 legal, no special case).
// CONFIGURATION
//  Macro YSYX_24090012_IFU_MISALIGN_EN:
//   defined: in S_REQ with pc[1:0]!=0, issue no memory request. Next cycle go to S_OUT
//     with inst=NOP_INST, inst_fault=1, inst_pc=pc.
//   undefined: pc[1:0] is ignored; the request goes out to {pc[31:2],2'b00}, with inst_fault
//     driven only by imem_rsp_err.
// STRUCTURE
//  Shared package ysyx_24090012_pkg: fetch state encoding (S_REQ/S_WAIT/S_OUT/S_NPC),
//  RESET_PC and NOP_INST constants, and the ebreak/ecall/mret encodings used by decode.
//  No sub-module: a single flat module with one FSM, pc register and output holding registers.
// TESTING
//  1. Reset then ready=1, rsp after 1 cycle with data 0x00100093, npc=0x80000004
//     -> req addr 0x80000000; inst_valid at T+2 with inst_pc 0x80000000; next req addr 0x80000004.
//  2. Hold imem_req_ready=0 for 5 cycles -> req_valid stays 1 and addr stays constant;
//     no state advance.
//  3. inst_ready low for 3 cycles -> inst/inst_pc/inst_fault stable;
//     no new request until npc_valid.
//  4. rsp_err=1 -> inst=0x00000013, inst_fault=1; pc is then updated normally
//     from npc (e.g. mtvec 0x80000100).
//  5. npc=0x80000002: with MISALIGN_EN -> no request, fault with inst_pc 0x80000002;
//     without it -> request to 0x80000000.
//  6. Assert rst while in S_WAIT, with a stale rsp arriving during reset -> after reset,
//     pc=0x80000000, inst_valid=0, and a fresh request is issued.

Source files
------------

// File: rtl/ysyx_24090012_pkg.sv
// Shared fetch/decode definitions: fetch FSM encoding, boot constants and system instruction encodings.
package ysyx_24090012_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] FETCH_RESET_PC = 32'h8000_0000;
    localparam logic [XLEN-1:0] FETCH_NOP_INST = 32'h0000_0013;

    localparam logic [XLEN-1:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [XLEN-1:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [XLEN-1:0] INST_MRET   = 32'h3020_0073;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2,
        S_NPC  = 2'd3
    } fetch_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_24090012_fetch_stage.sv
// Non-speculative multi-cycle fetch stage: one imem request per instruction, held until decode takes it.
// Optional YSYX_24090012_IFU_MISALIGN_EN turns a misaligned PC into a local fetch fault.
module ysyx_24090012_fetch_stage
    import ysyx_24090012_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = FETCH_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INST = FETCH_NOP_INST
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault,
    input  logic            npc_valid,
    input  logic [XLEN-1:0] npc,
    output logic [XLEN-1:0] pc
);

    fetch_state_t    state, state_n;
    logic [XLEN-1:0] pc_n, inst_n, inst_pc_n;
    logic            inst_fault_n, req_valid_n, inst_valid_n;
    logic            pc_misaligned, pc_n_misaligned;

`ifdef YSYX_24090012_IFU_MISALIGN_EN
    assign pc_misaligned   = (pc[1:0] != 2'b00);
    assign pc_n_misaligned = (pc_n[1:0] != 2'b00);
`else
    assign pc_misaligned   = 1'b0;
    assign pc_n_misaligned = 1'b0;
`endif

    // State, PC and output holding registers; valids are precomputed from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_REQ;
            pc             <= RESET_PC;
            imem_req_addr  <= word_align(RESET_PC);
            imem_req_valid <= 1'b0;
            inst_valid     <= 1'b0;
            inst           <= '0;
            inst_pc        <= '0;
            inst_fault     <= 1'b0;
        end else begin
            state          <= state_n;
            pc             <= pc_n;
            imem_req_addr  <= word_align(pc_n);
            imem_req_valid <= req_valid_n;
            inst_valid     <= inst_valid_n;
            inst           <= inst_n;
            inst_pc        <= inst_pc_n;
            inst_fault     <= inst_fault_n;
        end
    end

    // Next-state and holding-register update logic.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        inst_n       = inst;
        inst_pc_n    = inst_pc;
        inst_fault_n = inst_fault;

        unique case (state)
            S_REQ: begin
                if (pc_misaligned) begin
                    inst_n       = NOP_INST;
                    inst_pc_n    = pc;
                    inst_fault_n = 1'b1;
                    state_n      = S_OUT;
                end else if (imem_req_valid && imem_req_ready) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    inst_n       = imem_rsp_err ? NOP_INST : imem_rsp_data;
                    inst_pc_n    = pc;
                    inst_fault_n = imem_rsp_err;
                    state_n      = S_OUT;
                end
            end
            S_OUT: begin
                if (inst_ready) begin
                    state_n = S_NPC;
                end
            end
            S_NPC: begin
                if (npc_valid) begin
                    pc_n    = npc;
                    state_n = S_REQ;
                end
            end
            default: state_n = S_REQ;
        endcase

        // A misaligned PC never reaches the memory bus.
        req_valid_n  = (state_n == S_REQ) && !pc_n_misaligned;
        inst_valid_n = (state_n == S_OUT);
    end

endmodule

// File: tb/tb_ysyx_24090012_fetch_stage.sv
// Randomized bench for the fetch stage: a transaction-level memory/decode/execute model
// tracks the architectural PC and the instruction each fetch must deliver.
module tb_ysyx_24090012_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
`ifdef YSYX_24090012_IFU_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    localparam int PH_FETCH = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_HOLD  = 2;
    localparam int PH_NPC   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid, imem_rsp_err;
    logic [31:0] imem_rsp_data;
    logic        inst_valid, inst_ready, inst_fault;
    logic [31:0] inst, inst_pc;
    logic        npc_valid;
    logic [31:0] npc, pc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ysyx_24090012_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .npc_valid      (npc_valid),
        .npc            (npc),
        .pc             (pc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] next_pc(input logic [31:0] cur);
        int unsigned r;
        r = $urandom_range(0, 9);
        case (r)
            0, 1, 2, 3, 4: return cur + 32'd4;
            5:             return cur;
            6:             return 32'h8000_0000 + ($urandom & 32'h0000_fffc);
            7:             return cur + 32'd2;
            8:             return 32'hffff_fffc;
            default:       return (cur == 32'hffff_fffc) ? 32'h0 : 32'h8000_0100;
        endcase
    endfunction

    logic [31:0] pc_m, exp_inst, exp_pc, rsp_word;
    logic        exp_fault, rsp_bad;
    int          phase, lat, dly, wait_cnt;
    bit          just_npc, directed, did_reset;

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;
        npc_valid      = 1'b0;
        npc            = '0;

        repeat (2) begin
            @(negedge clk);
            check("rst_req_valid", 32'(imem_req_valid), 32'd0);
            check("rst_inst_valid", 32'(inst_valid), 32'd0);
        end
        check("rst_pc", pc, RESET_PC);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_inst_fault", 32'(inst_fault), 32'd0);
        rst = 1'b0;

        pc_m      = RESET_PC;
        phase     = PH_FETCH;
        just_npc  = 1'b0;
        directed  = 1'b1;
        did_reset = 1'b0;
        wait_cnt  = 0;
        lat       = 0;
        dly       = 0;
        exp_inst  = '0;
        exp_pc    = '0;
        exp_fault = 1'b0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            imem_req_ready = 1'b0;
            imem_rsp_valid = 1'b0;
            imem_rsp_err   = 1'b0;
            imem_rsp_data  = $urandom;
            inst_ready     = 1'b0;
            npc_valid      = 1'b0;
            npc            = $urandom;

            check("pc", pc, pc_m);

            // Reset while a response is outstanding, with a stale response arriving under reset.
            if (phase == PH_WAIT && !did_reset && cyc >= 1500) begin
                rst            = 1'b1;
                imem_rsp_valid = 1'b1;
                repeat (2) begin
                    @(negedge clk);
                    check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
                    check("midrst_inst_valid", 32'(inst_valid), 32'd0);
                end
                check("midrst_pc", pc, RESET_PC);
                rst            = 1'b0;
                imem_rsp_valid = 1'b0;
                pc_m      = RESET_PC;
                phase     = PH_FETCH;
                just_npc  = 1'b0;
                wait_cnt  = 0;
                did_reset = 1'b1;
                continue;
            end

            case (phase)
                PH_FETCH: begin
                    check("fetch_inst_valid", 32'(inst_valid), 32'd0);
                    imem_rsp_valid = ($urandom_range(0, 3) == 0);
                    npc_valid      = ($urandom_range(0, 3) == 0);
                    if (MIS_EN && pc_m[1:0] != 2'b00) begin
                        check("misalign_no_req", 32'(imem_req_valid), 32'd0);
                        imem_req_ready = 1'($urandom_range(0, 1));
                        exp_inst  = NOP_INST;
                        exp_pc    = pc_m;
                        exp_fault = 1'b1;
                        phase     = PH_HOLD;
                    end else begin
                        if (just_npc)
                            check("req_latency", 32'(imem_req_valid), 32'd1);
                        if (imem_req_valid) begin
                            check("req_addr", imem_req_addr, {pc_m[31:2], 2'b00});
                            imem_req_ready = directed ? 1'b1 : ($urandom_range(0, 9) < 7);
                            wait_cnt = 0;
                            if (imem_req_ready) begin
                                lat   = directed ? 1 : int'($urandom_range(1, 3));
                                phase = PH_WAIT;
                            end
                        end else begin
                            wait_cnt++;
                            if (wait_cnt > 8) begin
                                check("req_timeout", 32'(imem_req_valid), 32'd1);
                                wait_cnt = 0;
                            end
                        end
                    end
                    just_npc = 1'b0;
                end
                PH_WAIT: begin
                    check("wait_req_valid", 32'(imem_req_valid), 32'd0);
                    check("wait_inst_valid", 32'(inst_valid), 32'd0);
                    npc_valid = ($urandom_range(0, 3) == 0);
                    lat--;
                    if (lat <= 0) begin
                        rsp_word = directed ? 32'h0010_0093 : $urandom;
                        rsp_bad  = directed ? 1'b0 : ($urandom_range(0, 5) == 0);
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = rsp_word;
                        imem_rsp_err   = rsp_bad;
                        exp_inst  = rsp_bad ? NOP_INST : rsp_word;
                        exp_pc    = pc_m;
                        exp_fault = rsp_bad;
                        phase     = PH_HOLD;
                    end
                end
                PH_HOLD: begin
                    check("hold_inst_valid", 32'(inst_valid), 32'd1);
                    check("hold_inst", inst, exp_inst);
                    check("hold_inst_pc", inst_pc, exp_pc);
                    check("hold_inst_fault", 32'(inst_fault), 32'(exp_fault));
                    check("hold_req_valid", 32'(imem_req_valid), 32'd0);
                    imem_rsp_valid = ($urandom_range(0, 3) == 0);
                    npc_valid      = ($urandom_range(0, 2) == 0);
                    inst_ready     = directed ? 1'b1 : ($urandom_range(0, 9) < 6);
                    if (inst_ready) begin
                        dly   = directed ? 0 : int'($urandom_range(0, 2));
                        phase = PH_NPC;
                    end
                end
                default: begin
                    check("npc_inst_valid", 32'(inst_valid), 32'd0);
                    check("npc_req_valid", 32'(imem_req_valid), 32'd0);
                    imem_rsp_valid = ($urandom_range(0, 3) == 0);
                    if (dly == 0) begin
                        npc       = directed ? 32'h8000_0004 : next_pc(pc_m);
                        npc_valid = 1'b1;
                        pc_m      = npc;
                        phase     = PH_FETCH;
                        just_npc  = 1'b1;
                        wait_cnt  = 0;
                        directed  = 1'b0;
                    end else begin
                        dly--;
                    end
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
